// File: rtl/axi_lite_xbar_map_ctrl.sv
// Runtime address-map controller: gates crossbar Ax beats, drains outstanding traffic, then swaps the map.
// Optional drain-cycle statistics output enabled by AXI_LITE_XBAR_MAP_CTRL_STATS_EN.
package axi_pkg;
    typedef struct packed {
        int unsigned idx;
        logic [63:0] start_addr;
        logic [63:0] end_addr;
    } xbar_rule_64_t;
endpackage

module axi_lite_xbar_map_ctrl #(
    parameter int unsigned NumSlvPorts  = 2,
    parameter int unsigned NumMstPorts  = 4,
    parameter int unsigned NumAddrRules = 4,
    parameter int unsigned MaxTrans     = 8,
    parameter type rule_t = axi_pkg::xbar_rule_64_t,
    localparam int unsigned MstIdxWidth = (NumMstPorts > 1) ? $clog2(NumMstPorts) : 1
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [NumSlvPorts-1:0]                 slv_aw_valid_i,
    input  logic [NumSlvPorts-1:0]                 slv_ar_valid_i,
    output logic [NumSlvPorts-1:0]                 slv_aw_ready_o,
    output logic [NumSlvPorts-1:0]                 slv_ar_ready_o,
    output logic [NumSlvPorts-1:0]                 xbar_aw_valid_o,
    output logic [NumSlvPorts-1:0]                 xbar_ar_valid_o,
    input  logic [NumSlvPorts-1:0]                 xbar_aw_ready_i,
    input  logic [NumSlvPorts-1:0]                 xbar_ar_ready_i,
    input  logic [NumSlvPorts-1:0]                 b_hs_i,
    input  logic [NumSlvPorts-1:0]                 r_hs_i,
    input  logic                                   upd_valid_i,
    output logic                                   upd_ready_o,
    input  rule_t [NumAddrRules-1:0]               upd_map_i,
    input  logic [NumSlvPorts-1:0]                 upd_en_default_i,
    input  logic [NumSlvPorts-1:0][MstIdxWidth-1:0] upd_default_i,
    output logic                                   upd_done_o,
    output rule_t [NumAddrRules-1:0]               addr_map_o,
    output logic [NumSlvPorts-1:0]                 en_default_mst_port_o,
    output logic [NumSlvPorts-1:0][MstIdxWidth-1:0] default_mst_port_o,
    output logic                                   busy_o
`ifdef AXI_LITE_XBAR_MAP_CTRL_STATS_EN
    ,
    output logic [15:0]                            drain_cycles_o
`endif
);
    localparam int unsigned CntWidth = $clog2(MaxTrans + 1);
    localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxTrans);

    typedef enum logic [1:0] {IDLE, DRAIN, SWAP} state_e;

    state_e state_q, state_d;
    logic [NumSlvPorts-1:0] aw_pend_q, aw_pend_d, ar_pend_q, ar_pend_d;
    logic [NumSlvPorts-1:0] blk_aw, blk_ar, aw_open, ar_open, aw_hs, ar_hs;
    logic [CntWidth-1:0] wr_cnt_q [NumSlvPorts];
    logic [CntWidth-1:0] wr_cnt_d [NumSlvPorts];
    logic [CntWidth-1:0] rd_cnt_q [NumSlvPorts];
    logic [CntWidth-1:0] rd_cnt_d [NumSlvPorts];
    rule_t [NumAddrRules-1:0] map_q, map_d, sh_map_q, sh_map_d;
    logic [NumSlvPorts-1:0] en_q, en_d, sh_en_q, sh_en_d;
    logic [NumSlvPorts-1:0][MstIdxWidth-1:0] dflt_q, dflt_d, sh_dflt_q, sh_dflt_d;
    logic accept, drained;

    for (genvar gi = 0; gi < NumSlvPorts; gi++) begin : g_gate
        assign blk_aw[gi]  = (state_q != IDLE) | (wr_cnt_q[gi] == CntMax);
        assign blk_ar[gi]  = (state_q != IDLE) | (rd_cnt_q[gi] == CntMax);
        // A beat already presented to the crossbar stays presented until it handshakes.
        assign aw_open[gi] = aw_pend_q[gi] | ~blk_aw[gi];
        assign ar_open[gi] = ar_pend_q[gi] | ~blk_ar[gi];
        assign xbar_aw_valid_o[gi] = slv_aw_valid_i[gi] & aw_open[gi];
        assign xbar_ar_valid_o[gi] = slv_ar_valid_i[gi] & ar_open[gi];
        assign slv_aw_ready_o[gi]  = xbar_aw_ready_i[gi] & aw_open[gi];
        assign slv_ar_ready_o[gi]  = xbar_ar_ready_i[gi] & ar_open[gi];
        assign aw_hs[gi] = xbar_aw_valid_o[gi] & xbar_aw_ready_i[gi];
        assign ar_hs[gi] = xbar_ar_valid_o[gi] & xbar_ar_ready_i[gi];

        assert property (@(posedge clk_i) disable iff (rst_i)
            !(b_hs_i[gi] && !aw_hs[gi] && (wr_cnt_q[gi] == '0)));
        assert property (@(posedge clk_i) disable iff (rst_i)
            !(r_hs_i[gi] && !ar_hs[gi] && (rd_cnt_q[gi] == '0)));
    end

    assign accept      = (state_q == IDLE) & upd_valid_i;
    assign upd_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign upd_done_o  = (state_q == SWAP);

    // Drain is judged on next-cycle values so SWAP follows the final response directly.
    always_comb begin
        drained = 1'b1;
        for (int i = 0; i < NumSlvPorts; i++) begin
            wr_cnt_d[i] = wr_cnt_q[i];
            if (aw_hs[i] && !b_hs_i[i]) begin
                wr_cnt_d[i] = wr_cnt_q[i] + CntWidth'(1);
            end else if (!aw_hs[i] && b_hs_i[i] && (wr_cnt_q[i] != '0)) begin
                wr_cnt_d[i] = wr_cnt_q[i] - CntWidth'(1);
            end
            rd_cnt_d[i] = rd_cnt_q[i];
            if (ar_hs[i] && !r_hs_i[i]) begin
                rd_cnt_d[i] = rd_cnt_q[i] + CntWidth'(1);
            end else if (!ar_hs[i] && r_hs_i[i] && (rd_cnt_q[i] != '0)) begin
                rd_cnt_d[i] = rd_cnt_q[i] - CntWidth'(1);
            end
            aw_pend_d[i] = aw_hs[i] ? 1'b0 : (xbar_aw_valid_o[i] ? 1'b1 : aw_pend_q[i]);
            ar_pend_d[i] = ar_hs[i] ? 1'b0 : (xbar_ar_valid_o[i] ? 1'b1 : ar_pend_q[i]);
            if ((wr_cnt_d[i] != '0) || (rd_cnt_d[i] != '0) || aw_pend_d[i] || ar_pend_d[i]) begin
                drained = 1'b0;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        sh_map_d  = sh_map_q;
        sh_en_d   = sh_en_q;
        sh_dflt_d = sh_dflt_q;
        map_d     = map_q;
        en_d      = en_q;
        dflt_d    = dflt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = DRAIN;
                    sh_map_d  = upd_map_i;
                    sh_en_d   = upd_en_default_i;
                    sh_dflt_d = upd_default_i;
                end
            end
            DRAIN: begin
                if (drained) begin
                    state_d = SWAP;
                    map_d   = sh_map_q;
                    en_d    = sh_en_q;
                    dflt_d  = sh_dflt_q;
                end
            end
            SWAP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef AXI_LITE_XBAR_MAP_CTRL_STATS_EN
    logic [15:0] drain_cycles_q, drain_cycles_d;
    always_comb begin
        drain_cycles_d = drain_cycles_q;
        if (accept) begin
            drain_cycles_d = '0;
        end else if ((state_q == DRAIN) && (drain_cycles_q != 16'hFFFF)) begin
            drain_cycles_d = drain_cycles_q + 16'd1;
        end
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) drain_cycles_q <= '0;
        else       drain_cycles_q <= drain_cycles_d;
    end
    assign drain_cycles_o = drain_cycles_q;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            aw_pend_q <= '0;
            ar_pend_q <= '0;
            for (int i = 0; i < NumSlvPorts; i++) begin
                wr_cnt_q[i] <= '0;
                rd_cnt_q[i] <= '0;
            end
            sh_map_q  <= '0;
            sh_en_q   <= '0;
            sh_dflt_q <= '0;
            map_q     <= '0;
            en_q      <= '0;
            dflt_q    <= '0;
        end else begin
            state_q   <= state_d;
            aw_pend_q <= aw_pend_d;
            ar_pend_q <= ar_pend_d;
            for (int i = 0; i < NumSlvPorts; i++) begin
                wr_cnt_q[i] <= wr_cnt_d[i];
                rd_cnt_q[i] <= rd_cnt_d[i];
            end
            sh_map_q  <= sh_map_d;
            sh_en_q   <= sh_en_d;
            sh_dflt_q <= sh_dflt_d;
            map_q     <= map_d;
            en_q      <= en_d;
            dflt_q    <= dflt_d;
        end
    end

    assign addr_map_o            = map_q;
    assign en_default_mst_port_o = en_q;
    assign default_mst_port_o    = dflt_q;
endmodule

// File: tb/tb_axi_lite_xbar_map_ctrl.sv
// Self-checking bench for axi_lite_xbar_map_ctrl: gating vector table plus update/drain sequences
// with a scoreboard of expected configurations popped on each upd_done_o pulse.
module tb_axi_lite_xbar_map_ctrl;
    typedef axi_pkg::xbar_rule_64_t rule_t;

    typedef struct {
        rule_t [3:0]      map;
        logic [1:0]       en;
        logic [1:0][1:0]  dflt;
    } cfg_t;

    typedef struct {
        logic [1:0] aw_v, aw_r, ar_v, ar_r;
        logic [1:0] x_aw_v, s_aw_r, x_ar_v, s_ar_r;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [1:0]       slv_aw_valid, slv_ar_valid, xbar_aw_ready, xbar_ar_ready, b_hs, r_hs;
    logic [1:0]       slv_aw_ready, slv_ar_ready, xbar_aw_valid, xbar_ar_valid;
    logic             upd_valid, upd_ready, upd_done, busy;
    rule_t [3:0]      upd_map, addr_map;
    logic [1:0]       upd_en, en_def;
    logic [1:0][1:0]  upd_dflt, dflt;
`ifdef AXI_LITE_XBAR_MAP_CTRL_STATS_EN
    logic [15:0]      drain_cycles;
`endif

    axi_lite_xbar_map_ctrl dut (
        .clk_i                 (clk),
        .rst_i                 (rst),
        .slv_aw_valid_i        (slv_aw_valid),
        .slv_ar_valid_i        (slv_ar_valid),
        .slv_aw_ready_o        (slv_aw_ready),
        .slv_ar_ready_o        (slv_ar_ready),
        .xbar_aw_valid_o       (xbar_aw_valid),
        .xbar_ar_valid_o       (xbar_ar_valid),
        .xbar_aw_ready_i       (xbar_aw_ready),
        .xbar_ar_ready_i       (xbar_ar_ready),
        .b_hs_i                (b_hs),
        .r_hs_i                (r_hs),
        .upd_valid_i           (upd_valid),
        .upd_ready_o           (upd_ready),
        .upd_map_i             (upd_map),
        .upd_en_default_i      (upd_en),
        .upd_default_i         (upd_dflt),
        .upd_done_o            (upd_done),
        .addr_map_o            (addr_map),
        .en_default_mst_port_o (en_def),
        .default_mst_port_o    (dflt),
        .busy_o                (busy)
`ifdef AXI_LITE_XBAR_MAP_CTRL_STATS_EN
        ,
        .drain_cycles_o        (drain_cycles)
`endif
    );

    int   n_vec = 0;
    int   n_err = 0;
    cfg_t sb[$];
    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here, checks follow settle().
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic cfg_t make_cfg(input int s);
        cfg_t c;
        for (int k = 0; k < 4; k++) begin
            c.map[k].idx        = 32'(s + k);
            c.map[k].start_addr = 64'(s) * 64'h1_0000 + 64'(k) * 64'h100;
            c.map[k].end_addr   = 64'(s) * 64'h1_0000 + 64'(k) * 64'h100 + 64'hFF;
        end
        c.en      = 2'(s);
        c.dflt[0] = 2'(s);
        c.dflt[1] = 2'(s + 1);
        return c;
    endfunction

    task automatic request(input cfg_t c);
        upd_map   = c.map;
        upd_en    = c.en;
        upd_dflt  = c.dflt;
        upd_valid = 1'b1;
        sb.push_back(c);
    endtask

    task automatic check_swap(input string name);
        cfg_t e;
        check({name, "_done"}, 64'(upd_done), 64'd1);
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_sb: done seen with empty scoreboard, expected pending entry", name);
        end else begin
            e = sb.pop_front();
            check({name, "_idx0"},   64'(addr_map[0].idx), 64'(e.map[0].idx));
            check({name, "_start0"}, addr_map[0].start_addr, e.map[0].start_addr);
            check({name, "_map"},    64'(addr_map == e.map), 64'd1);
            check({name, "_en"},     64'(en_def), 64'(e.en));
            check({name, "_dflt"},   64'(dflt), 64'(e.dflt));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cfg_t c1, c2, c3, c4, c5;
        vecs[0] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        vecs[1] = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00};
        vecs[2] = '{2'b00, 2'b11, 2'b10, 2'b10, 2'b00, 2'b11, 2'b10, 2'b10};
        vecs[3] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11};
        vecs[4] = '{2'b10, 2'b11, 2'b01, 2'b11, 2'b10, 2'b11, 2'b01, 2'b11};
        vecs[5] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
        vecs[6] = '{2'b01, 2'b11, 2'b10, 2'b11, 2'b01, 2'b11, 2'b10, 2'b11};
        vecs[7] = '{2'b11, 2'b11, 2'b00, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00};

        rst = 1'b1; upd_valid = 1'b0; upd_map = '0; upd_en = '0; upd_dflt = '0;
        slv_aw_valid = '0; slv_ar_valid = '0; xbar_aw_ready = '0; xbar_ar_ready = '0;
        b_hs = '0; r_hs = '0;
        repeat (3) tick();
        rst = 1'b0;
        settle();
        check("rst_ready", 64'(upd_ready), 64'd1);
        check("rst_busy",  64'(busy), 64'd0);
        check("rst_done",  64'(upd_done), 64'd0);
        check("rst_map",   64'(|addr_map), 64'd0);
        check("rst_en",    64'(en_def), 64'd0);
        check("rst_dflt",  64'(dflt), 64'd0);

        // Gating table in IDLE with empty counters; every handshake is answered next cycle.
        for (int v = 0; v < 8; v++) begin
            tick();
            slv_aw_valid = vecs[v].aw_v; xbar_aw_ready = vecs[v].aw_r;
            slv_ar_valid = vecs[v].ar_v; xbar_ar_ready = vecs[v].ar_r;
            settle();
            check($sformatf("vec%0d_xaw_v", v), 64'(xbar_aw_valid), 64'(vecs[v].x_aw_v));
            check($sformatf("vec%0d_saw_r", v), 64'(slv_aw_ready),  64'(vecs[v].s_aw_r));
            check($sformatf("vec%0d_xar_v", v), 64'(xbar_ar_valid), 64'(vecs[v].x_ar_v));
            check($sformatf("vec%0d_sar_r", v), 64'(slv_ar_ready),  64'(vecs[v].s_ar_r));
            tick();
            slv_aw_valid = '0; slv_ar_valid = '0; xbar_aw_ready = '0; xbar_ar_ready = '0;
            b_hs = vecs[v].x_aw_v & vecs[v].aw_r;
            r_hs = vecs[v].x_ar_v & vecs[v].ar_r;
            tick();
            b_hs = '0; r_hs = '0;
        end

        // Idle update: accept at T, DRAIN at T+1, SWAP at T+2, IDLE at T+3.
        c1 = make_cfg(5);
        c1.map[0].idx = 32'd1; c1.map[0].start_addr = 64'h1000; c1.map[0].end_addr = 64'h2000;
        tick();
        request(c1);
        settle();
        check("idle_accept_ready", 64'(upd_ready), 64'd1);
        tick();
        upd_valid = 1'b0; upd_map = '1; upd_en = '1; upd_dflt = '1;
        settle();
        check("idle_t1_ready", 64'(upd_ready), 64'd0);
        check("idle_t1_busy",  64'(busy), 64'd1);
        check("idle_t1_done",  64'(upd_done), 64'd0);
        tick();
        settle();
        check_swap("idle_t2");
        check("idle_t2_end0", addr_map[0].end_addr, 64'h2000);
`ifdef AXI_LITE_XBAR_MAP_CTRL_STATS_EN
        check("idle_stats", 64'(drain_cycles), 64'd1);
`endif
        tick();
        settle();
        check("idle_t3_busy",  64'(busy), 64'd0);
        check("idle_t3_ready", 64'(upd_ready), 64'd1);

        // Drain wait: three writes outstanding, responses on drain cycles 4, 7, 10.
        for (int k = 0; k < 3; k++) begin
            tick();
            slv_aw_valid[0] = 1'b1; xbar_aw_ready[0] = 1'b1;
            settle();
            check($sformatf("drain_aw%0d_ready", k), 64'(slv_aw_ready[0]), 64'd1);
        end
        tick();
        slv_aw_valid[0] = 1'b0;
        c2 = make_cfg(9);
        request(c2);
        tick();
        upd_valid = 1'b0;
        slv_aw_valid[0] = 1'b1; xbar_aw_ready[0] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            b_hs[0] = (k == 4) || (k == 7) || (k == 10);
            settle();
            check($sformatf("drain_c%0d_xaw_v", k), 64'(xbar_aw_valid[0]), 64'd0);
            check($sformatf("drain_c%0d_done", k), 64'(upd_done), 64'd0);
            tick();
        end
        b_hs = '0;
        settle();
        check_swap("drain_swap");
        check("drain_swap_xaw_v", 64'(xbar_aw_valid[0]), 64'd0);
`ifdef AXI_LITE_XBAR_MAP_CTRL_STATS_EN
        check("drain_stats", 64'(drain_cycles), 64'd10);
`endif
        tick();
        settle();
        check("drain_idle_xaw_v", 64'(xbar_aw_valid[0]), 64'd1);
        tick();
        slv_aw_valid[0] = 1'b0; xbar_aw_ready[0] = 1'b0;
        b_hs[0] = 1'b1;
        tick();
        b_hs = '0;

        // Pending AR on port 1 survives acceptance and holds DRAIN until it and its R finish.
        slv_ar_valid[1] = 1'b1; xbar_ar_ready[1] = 1'b0;
        c3 = make_cfg(12);
        request(c3);
        settle();
        check("pend_accept_xar_v", 64'(xbar_ar_valid[1]), 64'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            upd_valid = 1'b0;
            settle();
            check($sformatf("pend_hold%0d_xar_v", k), 64'(xbar_ar_valid[1]), 64'd1);
            check($sformatf("pend_hold%0d_done", k), 64'(upd_done), 64'd0);
        end
        xbar_ar_ready[1] = 1'b1;
        settle();
        check("pend_hs_sar_r", 64'(slv_ar_ready[1]), 64'd1);
        tick();
        settle();
        check("pend_after_xar_v", 64'(xbar_ar_valid[1]), 64'd0);
        check("pend_after_sar_r", 64'(slv_ar_ready[1]), 64'd0);
        check("pend_after_done",  64'(upd_done), 64'd0);
        slv_ar_valid[1] = 1'b0;
        tick();
        r_hs[1] = 1'b1;
        settle();
        check("pend_rhs_done", 64'(upd_done), 64'd0);
        tick();
        r_hs = '0;
        xbar_ar_ready[1] = 1'b0;
        settle();
        check_swap("pend_swap");
        tick();

        // MaxTrans: eight writes fill port 0; a response reopens it; AW with B holds the count.
        for (int k = 0; k < 8; k++) begin
            tick();
            slv_aw_valid[0] = 1'b1; xbar_aw_ready[0] = 1'b1;
            settle();
            check($sformatf("max_aw%0d_ready", k), 64'(slv_aw_ready[0]), 64'd1);
        end
        tick();
        b_hs[0] = 1'b1;
        settle();
        check("max_9th_ready", 64'(slv_aw_ready[0]), 64'd0);
        check("max_9th_xaw_v", 64'(xbar_aw_valid[0]), 64'd0);
        tick();
        settle();
        check("max_reopen_ready", 64'(slv_aw_ready[0]), 64'd1);
        tick();
        b_hs[0] = 1'b0;
        settle();
        check("max_refill_ready", 64'(slv_aw_ready[0]), 64'd1);
        tick();
        settle();
        check("max_full_again_ready", 64'(slv_aw_ready[0]), 64'd0);
        slv_aw_valid[0] = 1'b0; xbar_aw_ready[0] = 1'b0;
        b_hs[0] = 1'b1;
        repeat (8) tick();
        b_hs = '0;

        // Reset during DRAIN with a read outstanding on port 0.
        tick();
        slv_ar_valid[0] = 1'b1; xbar_ar_ready[0] = 1'b1;
        tick();
        slv_ar_valid[0] = 1'b0; xbar_ar_ready[0] = 1'b0;
        c4 = make_cfg(3);
        request(c4);
        tick();
        upd_valid = 1'b0;
        settle();
        check("rstmid_busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        settle();
        check("rstmid_ready", 64'(upd_ready), 64'd1);
        check("rstmid_busy",  64'(busy), 64'd0);
        check("rstmid_done",  64'(upd_done), 64'd0);
        check("rstmid_map",   64'(|addr_map), 64'd0);
        check("rstmid_en",    64'(en_def), 64'd0);
        check("rstmid_dflt",  64'(dflt), 64'd0);
        c5 = make_cfg(7);
        request(c5);
        tick();
        upd_valid = 1'b0;
        settle();
        check("rstmid_t1_done", 64'(upd_done), 64'd0);
        tick();
        settle();
        check_swap("rstmid_t2");
        tick();
        settle();
        check("rstmid_t3_busy", 64'(busy), 64'd0);
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
